// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage around the 4:1 next-address mux.
// Holds the PC, runs the instruction-fetch handshake, feeds PC+1 (inca) and
// the link-stack top (LRa) to the mux, loads the mux result (mux1op) back
// into the PC, and keeps a small circular link stack for call/return.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   start, halt         leave IDLE / return to IDLE from WAIT_NEXT
//   mux1op, pc_we       next address and its load strobe
//   call, ret           link-stack push / pop, qualified by an accepted pc_we
//   imem_req, imem_addr fetch request (held until imem_ack) and address
//   imem_ack            memory accepted / returned the instruction
//   ir_valid            one-cycle pulse the cycle after imem_ack
//   pc, inca, LRa       current PC, PC+1, link-stack top (0 when empty)
//   stk_ovf, stk_unf    sticky overflow / underflow flags
module pc_sequencer #(
    parameter int unsigned    AW        = 8,
    parameter logic [AW-1:0]  RESET_VEC = '0,
    parameter int unsigned    LS_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          halt,
    input  logic [AW-1:0] mux1op,
    input  logic          pc_we,
    input  logic          call,
    input  logic          ret,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    output logic          ir_valid,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] inca,
    output logic [AW-1:0] LRa,
    output logic          stk_ovf,
    output logic          stk_unf
);

    localparam int unsigned PW = $clog2(LS_DEPTH);
    localparam int unsigned CW = $clog2(LS_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_NEXT
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic                irv_q, irv_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [PW-1:0]       top_q, top_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       stk_q [LS_DEPTH];
    logic [AW-1:0]       stk_d [LS_DEPTH];
    logic [PW-1:0]       push_idx;

    assign inca      = pc_q + AW'(1);
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign ir_valid  = irv_q;
    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;
    assign LRa       = (cnt_q == '0) ? '0 : stk_q[top_q];

    // Entries live in a ring indexed by top_q; a push while full simply
    // advances top over the oldest entry, so the count saturates at LS_DEPTH.
    assign push_idx  = top_q + PW'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        irv_d    = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        top_d    = top_q;
        cnt_d    = cnt_q;
        stk_d    = stk_q;
        imem_req = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    irv_d   = 1'b1;
                    state_d = S_WAIT_NEXT;
                end
            end
            S_WAIT_NEXT: begin
                if (pc_we) begin
                    pc_d    = mux1op;
                    state_d = S_FETCH;
                    // call+ret on an empty stack degenerates to a plain push
                    if (call && (!ret || cnt_q == '0)) begin
                        top_d           = push_idx;
                        stk_d[push_idx] = inca;
                        if (cnt_q == CW'(LS_DEPTH)) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (call && ret) begin
                        stk_d[top_q] = inca;
                    end else if (ret) begin
                        if (cnt_q == '0) begin
                            unf_d = 1'b1;
                        end else begin
                            top_d = top_q - PW'(1);
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end else if (halt) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VEC;
            irv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            top_q   <= '0;
            cnt_q   <= '0;
            stk_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            irv_q   <= irv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            stk_q   <= stk_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// stimulus, checked against a queue-based reference model of the sequencer.
module tb_pc_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       halt;
    logic [7:0] mux1op;
    logic       pc_we;
    logic       call;
    logic       ret;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic       ir_valid;
    logic [7:0] pc;
    logic [7:0] inca;
    logic [7:0] LRa;
    logic       stk_ovf;
    logic       stk_unf;

    pc_sequencer #(.AW(8), .RESET_VEC(8'h00), .LS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .mux1op(mux1op),
        .pc_we(pc_we), .call(call), .ret(ret), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .ir_valid(ir_valid),
        .pc(pc), .inca(inca), .LRa(LRa), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    localparam int DEPTH = 4;
    int         m_state;          // 0 idle, 1 fetching, 2 waiting for next address
    int         m_pc;
    int         stk[$];           // back of queue is the top
    logic       m_ovf, m_unf;

    typedef struct {
        int   pc;
        int   lr;
        logic ovf;
        logic unf;
    } exp_t;
    exp_t exp_q[$];

    function automatic int m_top();
        if (stk.size() == 0) return 0;
        return stk[stk.size() - 1];
    endfunction

    function automatic int m_inca();
        return (m_pc + 1) % 256;
    endfunction

    task automatic m_reset();
        m_state = 0;
        m_pc    = 0;
        stk.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_update();
        int inc;
        if (rst) begin
            m_reset();
            return;
        end
        inc = m_inca();
        case (m_state)
            0: if (start) m_state = 1;
            1: if (imem_ack) begin
                   exp_q.push_back('{m_pc, m_top(), m_ovf, m_unf});
                   m_state = 2;
               end
            default: begin
                if (pc_we) begin
                    if (call && ret && stk.size() > 0) begin
                        stk[stk.size() - 1] = inc;
                    end else if (call) begin
                        stk.push_back(inc);
                        if (stk.size() > DEPTH) begin
                            void'(stk.pop_front());
                            m_ovf = 1'b1;
                        end
                    end else if (ret) begin
                        if (stk.size() == 0) m_unf = 1'b1;
                        else void'(stk.pop_back());
                    end
                    m_pc    = int'(mux1op);
                    m_state = 1;
                end else if (halt) begin
                    m_state = 0;
                end
            end
        endcase
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic clear_inputs();
        start = 0; halt = 0; pc_we = 0; call = 0; ret = 0; imem_ack = 0;
        mux1op = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_fetch(int n_wait);
        for (int i = 0; i < n_wait; i++) begin
            imem_ack = 1'b0;
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic do_load(logic [7:0] a, logic c, logic r, logic h);
        pc_we = 1'b1; mux1op = a; call = c; ret = r; halt = h;
        tick();
        clear_inputs();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("imem_req", 32'(imem_req), 32'(m_state == 1));
            check("pc", 32'(pc), 32'(m_pc));
            check("imem_addr", 32'(imem_addr), 32'(m_pc));
            check("inca", 32'(inca), 32'(m_inca()));
            check("LRa", 32'(LRa), 32'(m_top()));
            check("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
            check("stk_unf", 32'(stk_unf), 32'(m_unf));
            if (ir_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL ir_valid_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("irv_pc", 32'(pc), 32'(e.pc));
                    check("irv_LRa", 32'(LRa), 32'(e.lr));
                    check("irv_ovf", 32'(stk_ovf), 32'(e.ovf));
                    check("irv_unf", 32'(stk_unf), 32'(e.unf));
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                n_checks++;
                n_err++;
                $display("FAIL ir_valid_missing: got 0 expected 1 at %0t", $time);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] call_pc [5];
        logic [7:0] pops    [4];
        logic       r_ret;
        call_pc = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90};
        pops    = '{8'h91, 8'h71, 8'h51, 8'h31};

        clear_inputs();
        rst = 1'b1;
        m_reset();
        tick();
        tick();
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_req", 32'(imem_req), 32'h0);
        rst = 1'b0;

        // Basic fetch, then load 05 and fetch with a 3-cycle ack delay
        start = 1'b1; tick(); start = 1'b0;
        do_fetch(0);
        do_load(8'h05, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_req_held", 32'(imem_req), 32'h1);
            check("t2_addr", 32'(imem_addr), 32'h05);
        end
        imem_ack = 1'b1; tick(); imem_ack = 1'b0;
        check("t2_irv_pulse", 32'(ir_valid), 32'h1);
        tick();
        check("t2_irv_drop", 32'(ir_valid), 32'h0);
        do_load(8'h06, 0, 0, 0);
        check("t2_pc06", 32'(pc), 32'h06);
        check("t2_refetch", 32'(imem_req), 32'h1);

        // Call and return
        do_fetch(0); do_load(8'h20, 0, 0, 0);
        do_fetch(0); do_load(8'h80, 1, 0, 0);
        check("t3_pc80", 32'(pc), 32'h80);
        check("t3_lra21", 32'(LRa), 32'h21);
        do_fetch(1); do_load(8'h21, 0, 1, 0);
        check("t3_pc21", 32'(pc), 32'h21);
        check("t3_lra_empty", 32'(LRa), 32'h00);

        // Wrap of inca
        do_fetch(0); do_load(8'hFF, 0, 0, 0);
        check("t5_inca_wrap", 32'(inca), 32'h00);
        do_fetch(0); do_load(8'h00, 0, 0, 0);
        check("t5_pc00", 32'(pc), 32'h00);
        check("t5_noflag", 32'({stk_ovf, stk_unf}), 32'h0);

        // Overflow then underflow of the link stack
        for (int k = 0; k < 5; k++) begin
            do_fetch(0); do_load(call_pc[k], 0, 0, 0);
            do_fetch(0); do_load(8'hC0, 1, 0, 0);
        end
        check("t4_ovf", 32'(stk_ovf), 32'h1);
        check("t4_lra91", 32'(LRa), 32'h91);
        for (int k = 0; k < 4; k++) begin
            do_fetch(0); do_load(pops[k], 0, 1, 0);
            check("t4_pop_pc", 32'(pc), 32'(pops[k]));
        end
        check("t4_lra_empty", 32'(LRa), 32'h00);
        check("t4_no_unf_yet", 32'(stk_unf), 32'h0);
        do_fetch(0); do_load(8'h00, 0, 1, 0);
        check("t4_unf", 32'(stk_unf), 32'h1);
        check("t4_lra00", 32'(LRa), 32'h00);

        // pc_we beats halt; pc_we during FETCH is ignored
        do_fetch(0); do_load(8'h44, 0, 0, 1);
        check("t6_pc44", 32'(pc), 32'h44);
        check("t6_fetch", 32'(imem_req), 32'h1);
        pc_we = 1'b1; mux1op = 8'h99; call = 1'b1; tick(); clear_inputs();
        check("t6_ignored_pc", 32'(pc), 32'h44);
        check("t6_ignored_lr", 32'(LRa), 32'h00);
        do_fetch(0); do_load(8'h50, 1, 0, 0);
        do_fetch(0);
        halt = 1'b1; tick(); halt = 1'b0;
        check("halt_idle", 32'(imem_req), 32'h0);
        start = 1'b1; tick(); start = 1'b0;

        // Async reset while a fetch is outstanding
        check("t1_pre_req", 32'(imem_req), 32'h1);
        rst = 1'b1;
        #1;
        check("t1_req_drop", 32'(imem_req), 32'h0);
        check("t1_pc", 32'(pc), 32'h00);
        check("t1_lra", 32'(LRa), 32'h00);
        check("t1_flags", 32'({stk_ovf, stk_unf}), 32'h0);
        m_reset();
        tick();
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                clear_inputs();
                apply_reset();
                continue;
            end
            start    = ($urandom_range(0, 1) == 0);
            imem_ack = ($urandom_range(0, 2) == 0);
            pc_we    = ($urandom_range(0, 2) == 0);
            halt     = ($urandom_range(0, 5) == 0);
            call     = ($urandom_range(0, 3) == 0);
            r_ret    = ($urandom_range(0, 3) == 0);
            ret      = r_ret;
            case ($urandom_range(0, 2))
                0: mux1op = 8'($urandom_range(0, 255));
                1: mux1op = 8'(m_inca());
                default: mux1op = 8'(m_top());
            endcase
            tick();
        end
        clear_inputs();
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
